// File: rtl/video_pkg.sv
// video_pkg: shared constants, counter widths and the stage
// bundle for the raster scan-out path.
package video_pkg;

   localparam logic MODE_1BPP  = 1'b0;
   localparam logic MODE_24BPP = 1'b1;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;

   localparam int H_TOTAL_DEF =
      H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF =
      V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int H_CW_DEF  = cnt_w(H_TOTAL_DEF);
   localparam int V_CW_DEF  = cnt_w(V_TOTAL_DEF);
   localparam int PIX_W_DEF = cnt_w(H_ACTIVE_DEF * V_ACTIVE_DEF + 1);

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       md;
      logic [4:0] bit_idx;
   } pix_ctl_t;

endpackage

// File: rtl/video_scanout_if.sv
// video_scanout_if: framebuffer read port between the scan-out
// engine (master) and the framebuffer BRAM (slave).
interface video_scanout_if #(
   parameter int FB_AW = 19
) ();

   logic [FB_AW-1:0] framebuffer_addr;
   logic [31:0]      framebuffer_data;

   modport master (
      output framebuffer_addr,
      input  framebuffer_data
   );

   modport slave (
      input  framebuffer_addr,
      output framebuffer_data
   );

endinterface

// File: rtl/video_timing.sv
// video_timing: raster counters, active/sync windows, linear
// pixel index and frame-start strobe, all in counter (S0) time.
module video_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int PIX_W    = cnt_w(H_ACTIVE * V_ACTIVE + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             active,
   output logic             h_sync,
   output logic             v_sync,
   output logic             frame_start,
   output logic [PIX_W-1:0] pix_idx
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = cnt_w(H_TOTAL);
   localparam int VW = cnt_w(V_TOTAL);
   localparam int HS_LO = H_ACTIVE + H_FP;
   localparam int VS_LO = V_ACTIVE + V_FP;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_end;
   logic          v_end;
   logic          h_win;
   logic          v_win;

   always_comb begin
      h_end = h_cnt == HW'(H_TOTAL - 1);
      v_end = v_cnt == VW'(V_TOTAL - 1);
      active = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
      h_win = (32'(h_cnt) >= HS_LO) && (32'(h_cnt) < HS_LO + H_SYNC);
      v_win = (32'(v_cnt) >= VS_LO) && (32'(v_cnt) < VS_LO + V_SYNC);
      h_sync = h_win ? H_POL : ~H_POL;
      v_sync = v_win ? V_POL : ~V_POL;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
   end

   // pix_idx holds the index of the pixel at the current counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         pix_idx <= '0;
      end else begin
         h_cnt <= h_end ? '0 : h_cnt + 1'b1;
         if (h_end)
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
         if (h_end && v_end)
            pix_idx <= '0;
         else if (active)
            pix_idx <= pix_idx + 1'b1;
      end
   end

endmodule

// File: rtl/video_scanout.sv
// video_scanout: framebuffer fetch and pixel formatting on top of
// video_timing; 24 bpp direct or 1 bpp two-colour palette.
module video_scanout
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int FB_AW    = 19
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic [23:0]            fg_color,
   input  logic [23:0]            bg_color,
   video_scanout_if.master        fb,
   output logic [23:0]            hdmi_data,
   output logic                   hdmi_h,
   output logic                   hdmi_v,
   output logic                   hdmi_de,
   output logic                   frame_start
);

   localparam int PW = cnt_w(H_ACTIVE * V_ACTIVE + 1);

   localparam pix_ctl_t CTL_IDLE = '{
      de: 1'b0, hs: ~H_POL, vs: ~V_POL, fs: 1'b0,
      md: MODE_24BPP, bit_idx: 5'd0
   };

   if ((H_ACTIVE * V_ACTIVE) % 32 != 0) begin : g_bad_size
      $error("video_scanout: frame size not a multiple of 32");
   end
   if (longint'(H_ACTIVE) * V_ACTIVE > (longint'(1) << FB_AW))
   begin : g_bad_aw
      $error("video_scanout: 24 bpp frame exceeds FB_AW");
   end

   logic          act0;
   logic          hs0;
   logic          vs0;
   logic          fs0;
   logic [PW-1:0] pix_idx;
   logic          mode_q;
   pix_ctl_t      s0;
   pix_ctl_t      s1;
   pix_ctl_t      s2;
   logic [23:0]   pix_rgb;

   video_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .H_POL    (H_POL),
      .V_POL    (V_POL),
      .PIX_W    (PW)
   ) u_timing (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (act0),
      .h_sync      (hs0),
      .v_sync      (vs0),
      .frame_start (fs0),
      .pix_idx     (pix_idx)
   );

   // The first pixel of a frame already uses the mode being latched.
   always_comb begin
      s0         = CTL_IDLE;
      s0.de      = act0;
      s0.hs      = hs0;
      s0.vs      = vs0;
      s0.fs      = fs0;
      s0.md      = fs0 ? mode : mode_q;
      s0.bit_idx = pix_idx[4:0];
   end

   always_comb begin
      pix_rgb = '0;
      if (s2.de) begin
         if (s2.md == MODE_24BPP)
            pix_rgb = fb.framebuffer_data[23:0];
         else if (fb.framebuffer_data[s2.bit_idx])
            pix_rgb = fg_color;
         else
            pix_rgb = bg_color;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q              <= MODE_24BPP;
         fb.framebuffer_addr <= '0;
         s1                  <= CTL_IDLE;
         s2                  <= CTL_IDLE;
         hdmi_data           <= '0;
         hdmi_de             <= 1'b0;
         hdmi_h              <= ~H_POL;
         hdmi_v              <= ~V_POL;
         frame_start         <= 1'b0;
      end else begin
         if (fs0)
            mode_q <= mode;
         if (s0.md == MODE_24BPP)
            fb.framebuffer_addr <= FB_AW'(pix_idx);
         else
            fb.framebuffer_addr <= FB_AW'(pix_idx >> 5);
         s1          <= s0;
         s2          <= s1;
         hdmi_data   <= pix_rgb;
         hdmi_de     <= s2.de;
         hdmi_h      <= s2.hs;
         hdmi_v      <= s2.vs;
         frame_start <= s2.fs;
      end
   end

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: directed vectors on a 40x7 raster, two DUTs
// (sync polarity high and low) sharing clock, reset and controls.
module tb_video_scanout;

   localparam int AW = 8;
   localparam int NT = 600;

   typedef struct {
      int          frame;
      int          k;
      logic [23:0] data;
      logic [7:0]  addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode = 1'b1;
   logic [23:0] fg = 24'hFF0000;
   logic [23:0] bg = 24'h0000FF;

   logic [23:0] d_p, d_n;
   logic        h_p, v_p, de_p, fs_p;
   logic        h_n, v_n, de_n, fs_n;

   logic [31:0] mem [0:255];

   logic [23:0] t_data [0:NT-1];
   logic [7:0]  t_addr [0:NT-1];
   logic        t_de [0:NT-1];
   logic        t_h  [0:NT-1];
   logic        t_v  [0:NT-1];
   logic        t_fs [0:NT-1];
   logic        t_hn [0:NT-1];
   logic        t_vn [0:NT-1];

   int n_tests = 0;
   int n_fail  = 0;

   vec_t va [7];
   vec_t vb [15];

   always #5 clk = ~clk;

   video_scanout_if #(.FB_AW(AW)) fb_p ();
   video_scanout_if #(.FB_AW(AW)) fb_n ();

   always @(posedge clk) fb_p.framebuffer_data <= mem[fb_p.framebuffer_addr];
   always @(posedge clk) fb_n.framebuffer_data <= mem[fb_n.framebuffer_addr];

   video_scanout #(
      .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .FB_AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .fg_color(fg), .bg_color(bg), .fb(fb_p),
      .hdmi_data(d_p), .hdmi_h(h_p), .hdmi_v(v_p),
      .hdmi_de(de_p), .frame_start(fs_p)
   );

   video_scanout #(
      .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .FB_AW(AW)
   ) dut_n (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .fg_color(fg), .bg_color(bg), .fb(fb_n),
      .hdmi_data(d_n), .hdmi_h(h_n), .hdmi_v(v_n),
      .hdmi_de(de_n), .frame_start(fs_n)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fill_mem(input logic word0_five);
      for (int a = 0; a < 256; a++)
         mem[a] = {8'hA5, 24'(a * 24'h010101)};
      if (word0_five)
         mem[0] = 32'h0000_0005;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // cycle 0 is the first cycle with rst_n high; samples at negedge
   task automatic capture(input int n, input int sw_cyc,
                          input int rd_cyc, input int rd_len);
      for (int c = 0; c < n; c++) begin
         if (c > 0) @(negedge clk);
         t_data[c] = d_p;
         t_addr[c] = fb_p.framebuffer_addr;
         t_de[c]   = de_p;
         t_h[c]    = h_p;
         t_v[c]    = v_p;
         t_fs[c]   = fs_p;
         t_hn[c]   = h_n;
         t_vn[c]   = v_n;
         if (c == sw_cyc) mode = 1'b0;
         if (rd_cyc >= 0 && c == rd_cyc) rst_n = 1'b0;
         if (rd_cyc >= 0 && c == rd_cyc + rd_len) rst_n = 1'b1;
      end
   endtask

   task automatic chk_timing(input int f);
      int base, eh, ev, ed, ef, en, ez, ch, cv, cd;
      base = 3 + f * 280;
      eh = 0; ev = 0; ed = 0; ef = 0; en = 0; ez = 0;
      ch = 0; cv = 0; cd = 0;
      for (int r = 0; r < 280; r++) begin
         int  c, hx, vy;
         logic xh, xv, xd, xf;
         c  = base + r;
         hx = r % 40;
         vy = r / 40;
         xh = (hx >= 34 && hx < 37);
         xv = (vy == 5);
         xd = (hx < 32 && vy < 4);
         xf = (r == 0);
         if (t_h[c] !== xh) eh++;
         if (t_v[c] !== xv) ev++;
         if (t_de[c] !== xd) ed++;
         if (t_fs[c] !== xf) ef++;
         if (t_hn[c] !== ~xh || t_vn[c] !== ~xv) en++;
         if (!xd && t_data[c] !== 24'h0) ez++;
         if (t_h[c] === 1'b1) ch++;
         if (t_v[c] === 1'b1) cv++;
         if (t_de[c] === 1'b1) cd++;
      end
      chk($sformatf("h_window_f%0d", f), eh, 0);
      chk($sformatf("v_window_f%0d", f), ev, 0);
      chk($sformatf("de_window_f%0d", f), ed, 0);
      chk($sformatf("fs_window_f%0d", f), ef, 0);
      chk($sformatf("neg_pol_window_f%0d", f), en, 0);
      chk($sformatf("blank_data_f%0d", f), ez, 0);
      chk($sformatf("h_count_f%0d", f), ch, 21);
      chk($sformatf("v_count_f%0d", f), cv, 40);
      chk($sformatf("de_count_f%0d", f), cd, 128);
   endtask

   task automatic chk_vec(input string tag, input int i, input vec_t v);
      int cy;
      cy = 3 + v.frame * 280 + (v.k / 32) * 40 + v.k % 32;
      chk($sformatf("%s%0d_data_k%0d", tag, i, v.k), t_data[cy], v.data);
      chk($sformatf("%s%0d_de_k%0d", tag, i, v.k), t_de[cy], 1'b1);
      chk($sformatf("%s%0d_addr_k%0d", tag, i, v.k), t_addr[cy-2], v.addr);
   endtask

   task automatic chk_frame24(input int f);
      int ed, ea;
      ed = 0; ea = 0;
      for (int k = 0; k < 128; k++) begin
         int cy;
         cy = 3 + f * 280 + (k / 32) * 40 + k % 32;
         if (t_data[cy] !== 24'(k * 24'h010101)) ed++;
         if (t_addr[cy-2] !== 8'(k)) ea++;
      end
      chk($sformatf("rgb24_all_f%0d", f), ed, 0);
      chk($sformatf("addr24_all_f%0d", f), ea, 0);
   endtask

   initial begin
      va[0] = '{0, 0,   24'h000000, 8'd0};
      va[1] = '{0, 1,   24'h010101, 8'd1};
      va[2] = '{0, 31,  24'h1F1F1F, 8'd31};
      va[3] = '{0, 32,  24'h202020, 8'd32};
      va[4] = '{0, 95,  24'h5F5F5F, 8'd95};
      va[5] = '{1, 64,  24'h404040, 8'd64};
      va[6] = '{1, 127, 24'h7F7F7F, 8'd127};

      vb[0]  = '{0, 0,   24'h000005, 8'd0};
      vb[1]  = '{0, 1,   24'h010101, 8'd1};
      vb[2]  = '{0, 96,  24'h606060, 8'd96};
      vb[3]  = '{0, 127, 24'h7F7F7F, 8'd127};
      vb[4]  = '{1, 0,   24'hFF0000, 8'd0};
      vb[5]  = '{1, 1,   24'h0000FF, 8'd0};
      vb[6]  = '{1, 2,   24'hFF0000, 8'd0};
      vb[7]  = '{1, 3,   24'h0000FF, 8'd0};
      vb[8]  = '{1, 31,  24'h0000FF, 8'd0};
      vb[9]  = '{1, 32,  24'hFF0000, 8'd1};
      vb[10] = '{1, 33,  24'h0000FF, 8'd1};
      vb[11] = '{1, 40,  24'hFF0000, 8'd1};
      vb[12] = '{1, 62,  24'h0000FF, 8'd1};
      vb[13] = '{1, 63,  24'hFF0000, 8'd1};
      vb[14] = '{1, 127, 24'hFF0000, 8'd3};

      // timing, polarity and 24 bpp
      fill_mem(1'b0);
      mode = 1'b1;
      do_reset();
      capture(566, -1, -1, 0);
      chk("rst_de", t_de[0], 1'b0);
      chk("rst_data", t_data[0], 24'h0);
      chk("rst_fs", t_fs[0], 1'b0);
      chk("rst_h", t_h[0], 1'b0);
      chk("rst_v", t_v[0], 1'b0);
      chk("rst_addr", t_addr[0], 8'h0);
      chk("rst_h_negpol", t_hn[0], 1'b1);
      chk("rst_v_negpol", t_vn[0], 1'b1);
      chk("idle_de_c1", t_de[1], 1'b0);
      chk("idle_h_c2", t_h[2], 1'b0);
      chk("idle_fs_c2", t_fs[2], 1'b0);
      chk("idle_hn_c2", t_hn[2], 1'b1);
      chk_timing(0);
      chk_timing(1);
      chk("fs_clock3", t_fs[3], 1'b1);
      chk("fs_clock283", t_fs[283], 1'b1);
      for (int i = 0; i < 7; i++) chk_vec("A", i, va[i]);
      chk_frame24(0);
      chk_frame24(1);

      // mode switch to 1 bpp at v_cnt = 2
      fill_mem(1'b1);
      mode = 1'b1;
      do_reset();
      capture(566, 80, -1, 0);
      for (int i = 0; i < 15; i++) chk_vec("B", i, vb[i]);
      begin
         int ea;
         ea = 0;
         for (int k = 0; k < 32; k++)
            if (t_addr[283 + k - 2] !== 8'h0) ea++;
         chk("addr1bpp_hold0", ea, 0);
      end

      // reset dropped at v_cnt = 2, h_cnt = 10
      fill_mem(1'b0);
      mode = 1'b1;
      do_reset();
      capture(200, -1, 90, 3);
      chk("pre_rst_de", t_de[90], 1'b1);
      chk("pre_rst_data", t_data[90], 24'h474747);
      chk("pre_rst_addr", t_addr[90], 8'h49);
      chk("midrst_de", t_de[91], 1'b0);
      chk("midrst_data", t_data[91], 24'h0);
      chk("midrst_fs", t_fs[91], 1'b0);
      chk("midrst_h", t_h[91], 1'b0);
      chk("midrst_v", t_v[91], 1'b0);
      chk("midrst_addr", t_addr[91], 8'h0);
      chk("midrst_hn", t_hn[92], 1'b1);
      chk("midrst_vn", t_vn[92], 1'b1);
      chk("restart_addr0", t_addr[94], 8'h0);
      chk("restart_addr1", t_addr[95], 8'h1);
      chk("restart_fs_early", t_fs[95], 1'b0);
      chk("restart_fs", t_fs[96], 1'b1);
      chk("restart_de", t_de[96], 1'b1);
      chk("restart_pix1", t_data[97], 24'h010101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
